uart_tx_fifo_param: RTL and testbench

- Parametrised next-generation UART transmitter; replaces the fixed 8-bit, fixed-baud-table transmit top.
- Accepts words over a valid/ready handshake into an internal FIFO, then serialises them: start bit, configurable data bits (LSB first), optional parity, 1 or 2 stop bits.
- Bit period is set by a runtime-programmable clock divisor, not a fixed table.
- Sits between the system bus and the serial pin.

---
 rtl/uart_tx_fifo_param.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param
// UART transmitter with an internal first-word-fall-through FIFO. Words
// enter over a valid/ready handshake and are sent as: start bit, 5..MAX
// data bits LSB first, optional parity, one or two stop bits. The bit
// period is baud_div_i+1 clocks. Frame configuration and divisor are
// sampled when a word is popped, so mid-frame changes apply to the next
// frame.
//
// Ports
//   clock_i        system clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   baud_div_i     bit period minus one, in clocks
//   data_bits_i    data bits per frame (clamped to 5..MAX_DATA_BITS)
//   parity_type_i  00/11 none, 01 odd, 10 even
//   two_stop_i     1 = two stop bits
//   data_in_i      word to send; bits above data_bits_i ignored
//   in_valid_i     data_in_i valid
//   in_ready_o     FIFO not full
//   data_tx_o      serial line, idles high
//   active_flag_o  high while a frame is on the line
//   done_flag_o    one-clock pulse after each frame's last stop bit
//   fifo_count_o   entries held
//
// state  | meaning
// IDLE   | line high, waiting for a word in the FIFO
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | one or two stop bits (high)
module uart_tx_fifo_param #(
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 8,
  parameter int DIV_WIDTH     = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic [DIV_WIDTH-1:0]          baud_div_i,
  input  logic [3:0]                    data_bits_i,
  input  logic [1:0]                    parity_type_i,
  input  logic                          two_stop_i,
  input  logic [MAX_DATA_BITS-1:0]      data_in_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic                          data_tx_o,
  output logic                          active_flag_o,
  output logic                          done_flag_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [3:0]    MIN_BITS = 4'd5;
  localparam logic [3:0]    MAX_BITS = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q;
  logic                     push, pop, fifo_empty;

  assign in_ready_o   = (count_q != FULL);
  assign push         = in_valid_i && in_ready_o;
  assign fifo_empty   = (count_q == '0);
  assign fifo_count_o = count_q;

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= data_in_i;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- frame config for the head word ----------------
  logic [3:0]               nbits_cfg;
  logic [MAX_DATA_BITS-1:0] head_word, head_masked;
  logic                     par_en_cfg, par_cfg;

  assign head_word = mem_q[rd_ptr_q];

  always_comb begin
    nbits_cfg = data_bits_i;
    if (data_bits_i < MIN_BITS)      nbits_cfg = MIN_BITS;
    else if (data_bits_i > MAX_BITS) nbits_cfg = MAX_BITS;
  end

  always_comb begin
    head_masked = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++)
      head_masked[i] = head_word[i] & (i < int'(nbits_cfg));
  end

  assign par_en_cfg = (parity_type_i == 2'b01) || (parity_type_i == 2'b10);
  // even: XOR of data bits; odd: inverted
  assign par_cfg    = (^head_masked) ^ (parity_type_i == 2'b01);

  // ---------------- transmit FSM ----------------
  state_t                   state_q, state_d;
  logic [DIV_WIDTH-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]               nbits_q, nbits_d, bit_idx_q, bit_idx_d;
  logic                     par_en_q, par_en_d, par_q, par_d, two_q, two_d;
  logic                     stop_idx_q, stop_idx_d;
  logic                     tx_q, tx_d, active_q, active_d, done_q, done_d;
  logic                     bit_tick, load;

  assign bit_tick = (cnt_q == div_q);
  assign pop      = load;

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_tick ? '0 : cnt_q + DIV_WIDTH'(1);
    div_d      = div_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    bit_idx_d  = bit_idx_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    two_d      = two_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    active_d   = active_q;
    done_d     = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == nbits_q - 4'd1) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (two_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d  = IDLE;
              active_d = 1'b0;
              tx_d     = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tx_d     = 1'b1;
        active_d = 1'b0;
      end
    endcase

    // pop the head word and capture the frame config; start bit next clock
    if (load) begin
      state_d  = START;
      cnt_d    = '0;
      tx_d     = 1'b0;
      active_d = 1'b1;
      div_d    = baud_div_i;
      shift_d  = head_masked;
      nbits_d  = nbits_cfg;
      par_en_d = par_en_cfg;
      par_d    = par_cfg;
      two_d    = two_stop_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      nbits_q    <= MIN_BITS;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_q      <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      bit_idx_q  <= bit_idx_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      two_q      <= two_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign data_tx_o     = tx_q;
  assign active_flag_o = active_q;
  assign done_flag_o   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param. Stimulus pushes the expected line
// pattern of each accepted word into a queue; a monitor detects start
// bits, samples every bit period and compares against the queue head.
module tb_uart_tx_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  logic [1:0]  parity_type;
  logic        two_stop;
  logic [8:0]  data_in;
  logic        in_valid;
  logic        in_ready, data_tx, active_flag, done_flag;
  logic [3:0]  fifo_count;

  uart_tx_fifo_param #(.MAX_DATA_BITS(9), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .baud_div_i(baud_div),
    .data_bits_i(data_bits), .parity_type_i(parity_type), .two_stop_i(two_stop),
    .data_in_i(data_in), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_tx_o(data_tx), .active_flag_o(active_flag), .done_flag_o(done_flag),
    .fifo_count_o(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;   // line bits, bit 0 = start; unused upper bits are 1
    int          len;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int cur_div = 3;
  bit mon_en = 1'b1;
  int first_start = -1;
  int last_done = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_flag) begin
      done_cnt  <= done_cnt + 1;
      last_done <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic frame_t make_frame(input logic [8:0] w, input int nb, input int par, input bit two);
    frame_t f;
    logic x;
    int p;
    f.bits = '1;
    f.bits[0] = 1'b0;
    x = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f.bits[1+i] = w[i];
      x ^= w[i];
    end
    p = 1 + nb;
    if (par != 0) begin
      f.bits[p] = (par == 2) ? x : ~x;
      p++;
    end
    f.len = p + (two ? 2 : 1);
    return f;
  endfunction

  // monitor: compare each frame on the line with the scoreboard head
  initial begin : monitor
    frame_t f;
    logic [15:0] cap;
    logic act_ok;
    bit skip_done;
    int t;
    skip_done = 1'b0;
    @(negedge clk);
    forever begin
      if (mon_en && rst_n && data_tx === 1'b0) begin
        if (first_start < 0) first_start = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit seen with empty scoreboard (t=%0t)", $time);
          t = 0;
          while (data_tx === 1'b0 && t < 1000) begin @(negedge clk); t++; end
          skip_done = 1'b0;
        end else begin
          f = exp_q.pop_front();
          cap = '1;
          cap[0] = data_tx;
          act_ok = active_flag;
          for (int k = 1; k < f.len; k++) begin
            repeat (cur_div + 1) @(negedge clk);
            cap[k] = data_tx;
            act_ok &= active_flag;
          end
          check("frame_bits", 32'(cap), 32'(f.bits));
          check("active_during_frame", 32'(act_ok), 32'd1);
          repeat (cur_div + 1) @(negedge clk);
          check("done_at_frame_end", 32'(done_flag), 32'd1);
          skip_done = 1'b1;
        end
      end else begin
        if (mon_en && rst_n && !skip_done && done_flag === 1'b1) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: done_flag high outside frame end (t=%0t)", $time);
        end
        skip_done = 1'b0;
        @(negedge clk);
      end
    end
  end

  // call at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [8:0] w, input bit expect_it, input frame_t f);
    int t = 0;
    while (!in_ready && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0, expected 1");
    end
    data_in  = w;
    in_valid = 1'b1;
    if (expect_it) exp_q.push_back(f);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || active_flag) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: line still busy, expected idle");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_div(input int d);
    cur_div  = d;
    baud_div = 16'(d);
  endtask

  initial begin : stim
    frame_t f;
    int base;
    set_div(3);
    data_bits   = 4'd8;
    parity_type = 2'b00;
    two_stop    = 1'b0;
    data_in     = '0;
    in_valid    = 1'b0;

    // reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_tx", 32'(data_tx), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_active", 32'(active_flag), 32'd0);
    check("rst_done", 32'(done_flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_data_tx", 32'(data_tx), 32'd1);
    check("post_rst_fifo_count", 32'(fifo_count), 32'd0);

    // 8N1, div 3, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    f.bits = 16'hFF4A; f.len = 10;
    base = done_cnt; first_start = -1;
    push(9'h0A5, 1'b1, f);
    wait_drain();
    check("8n1_done_count", 32'(done_cnt - base), 32'd1);
    check("8n1_frame_clocks", 32'(last_done - first_start), 32'd40);
    check("8n1_active_fell", 32'(active_flag), 32'd0);
    check("8n1_line_idle", 32'(data_tx), 32'd1);

    // 7E2 then 7O2 with 0x53
    data_bits = 4'd7; parity_type = 2'b10; two_stop = 1'b1;
    f.bits = 16'hFEA6; f.len = 11;
    first_start = -1;
    push(9'h053, 1'b1, f);
    wait_drain();
    check("7e2_frame_clocks", 32'(last_done - first_start), 32'd44);
    parity_type = 2'b01;
    f.bits = 16'hFFA6; f.len = 11;
    push(9'h053, 1'b1, f);
    wait_drain();

    // data_bits clamping and ignored upper bits, div 1
    set_div(1);
    parity_type = 2'b00; two_stop = 1'b0;
    data_bits = 4'd3;
    push(9'h1F3, 1'b1, make_frame(9'h1F3, 5, 0, 1'b0));
    wait_drain();
    data_bits = 4'd15;
    push(9'h155, 1'b1, make_frame(9'h155, 9, 0, 1'b0));
    wait_drain();
    data_bits = 4'd8;
    parity_type = 2'b11;
    push(9'h1C3, 1'b1, make_frame(9'h1C3, 8, 0, 1'b0));
    wait_drain();

    // config change during DATA: current frame keeps 8 bits, next uses 5
    parity_type = 2'b00;
    push(9'h0B4, 1'b1, make_frame(9'h0B4, 8, 0, 1'b0));
    repeat (6) @(negedge clk);
    data_bits = 4'd5;
    push(9'h1ED, 1'b1, make_frame(9'h1ED, 5, 0, 1'b0));
    wait_drain();

    // FIFO full and back-to-back, div 0
    set_div(0);
    data_bits = 4'd8;
    base = done_cnt; first_start = -1;
    for (int i = 0; i < 9; i++)
      push(9'(i * 37 + 5), 1'b1, make_frame(9'(i * 37 + 5), 8, 0, 1'b0));
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_in_ready", 32'(in_ready), 32'd0);
    data_in = 9'h1AA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("full_ignored_count", 32'(fifo_count), 32'd8);
    wait_drain();
    check("b2b_done_count", 32'(done_cnt - base), 32'd9);
    check("b2b_total_clocks", 32'(last_done - first_start), 32'd90);
    check("b2b_fifo_empty", 32'(fifo_count), 32'd0);

    // reset during DATA with 3 words queued
    mon_en = 1'b0;
    set_div(3);
    for (int i = 0; i < 4; i++) push(9'h000, 1'b0, f);
    repeat (4) @(negedge clk);
    check("pre_rst_queued", 32'(fifo_count), 32'd3);
    check("pre_rst_line_low", 32'(data_tx), 32'd0);
    base = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_line_high", 32'(data_tx), 32'd1);
    check("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    check("mid_rst_active", 32'(active_flag), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_abort_no_done", 32'(done_cnt - base), 32'd0);
    check("post_abort_line", 32'(data_tx), 32'd1);
    check("post_abort_active", 32'(active_flag), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
